c17_response_checker: RTL
=========================

// Module: c17_response_checker
// PURPOSE
//  Observing end of the clocked_c17 test path: tracks each input vector applied to the DUT.
//  Computes the golden c17 NAND-network response, compares it against DUT N22/N23 after a
//  fixed pipeline latency, and reports per-run mismatch count, first failure and a MISR signature.
//  Sits beside clocked_c17; flags Trojan-induced deviations without a simulator-side checker.
// PARAMETERS
//  LATENCY  1   DUT cycles from vector applied to N22/N23 valid; legal 1..8
//  CNT_W    16  width of vector count, error count, failure index
// PORTS
//  clk              in   1      rising-edge clock
//  sync_reset       in   1      asynchronous, active-high reset
//  start            in   1      1-cycle pulse: begin a run (IDLE or DONE only)
//  num_vec          in   CNT_W  vectors in the run; sampled on accepted start
//  vec_valid        in   1      vector applied to DUT this cycle
//  vec_in           in   5      {N1,N2,N3,N6,N7} applied to DUT this cycle
//  N22, N23         in   1 ea   DUT outputs
//  busy             out  1      1 in RUN or DRAIN
//  done             out  1      1 in DONE
//  pass             out  1      done & (err_cnt==0)
//  err_cnt          out  CNT_W  mismatching compares; saturates at all-ones
//  first_fail_idx   out  CNT_W  0-based index of first mismatching vector
//  first_fail_exp   out  2      golden {N22,N23} at first mismatch
//  first_fail_got   out  2      DUT {N22,N23} at first mismatch
//  signature        out  16     MISR over DUT responses
// BEHAVIOUR
//  Reset (async, immediate): state IDLE; busy=done=pass=0; err_cnt, first_fail_*, signature,
//   accept/compare counters = 0; expected pipeline valid bits cleared.
//  Golden: n10=~(N1&N3) n11=~(N3&N6) n16=~(N2&n11) n19=~(n11&N7); exp22=~(n10&n16), exp23=~(n16&n19).
//  FSM: IDLE -start-> RUN (num_vec!=0) or DONE (num_vec==0, pass=1, no compares).
//   RUN: each vec_valid cycle accepts a vector; the accepted count reaching num_vec -> DRAIN.
//   DRAIN: vec_valid ignored; -> DONE the cycle after the last pending compare retires.
//   DONE: outputs held; start -> new run (clears err_cnt, first_fail_*, signature, counters).
//   start in RUN/DRAIN ignored.
//  Pipeline: accepted vector pushes {valid,exp22,exp23} into a LATENCY-deep shift register;
//   at stage LATENCY output valid, DUT {N22,N23} sampled that cycle is compared. Back-to-back
//   vectors supported at 1 per cycle; gaps in vec_valid propagate as bubbles (no compare).
//  Mismatch: err_cnt += 1 unless all-ones; on first mismatch capture index (compare count),
//   exp and got; later mismatches do not overwrite.
//  MISR per compare: sig = {sig[14:0],1'b0} ^ (sig[15] ? 16'h1021 : 0) ^ {14'b0,N22,N23}.
//  Index counts compares (0-based) independently of bubbles.
//  sync_reset mid-run aborts to IDLE; pending compares discarded.
// TESTING
//  LATENCY=1, num_vec=2, vectors 5'b00000 then 5'b11001, DUT correct (00, then 11) -> done, pass=1, err_cnt=0.
//  Same, DUT forces N23=0 on vector 1 -> err_cnt=1, first_fail_idx=1, exp=2'b11, got=2'b10, pass=0.
//  All 32 vectors back-to-back, correct DUT, LATENCY=3 -> done exactly 3 cycles after last accept, pass=1.
//  num_vec=0 start -> DONE next cycle, pass=1, signature=0; start during RUN -> no effect.
//  Assert sync_reset mid-run (async, between edges) -> outputs 0 immediately; new start runs cleanly.
//  Compare signature for a 4-vector run against the bench model of the MISR equation; gapped vec_valid gives identical result.

Source files
------------

// File: rtl/c17_response_checker.sv
// -----------------------------------------------------------------------------
// c17_response_checker
//
// Observing end of the clocked_c17 test path. Every vector accepted during a
// run has its golden c17 response {N22,N23} computed and pushed into a
// LATENCY-deep expected pipeline. When an entry reaches the end of the
// pipeline, the DUT outputs present in that cycle are compared against it.
// Per run the block reports the mismatch count, the first failing vector
// and a 16-bit MISR signature over the DUT responses.
//
// Parameters
//   LATENCY  DUT cycles from vector applied to N22/N23 valid (legal 1..8)
//   CNT_W    width of vector count, error count and failure index
//
// Ports
//   clk             in   rising-edge clock
//   sync_reset      in   asynchronous, active-high reset
//   start           in   1-cycle pulse, begins a run (honoured in IDLE/DONE)
//   num_vec         in   vectors in the run, sampled on an accepted start
//   vec_valid       in   a vector is applied to the DUT this cycle
//   vec_in          in   {N1,N2,N3,N6,N7} applied to the DUT this cycle
//   N22, N23        in   DUT outputs
//   busy            out  run in progress (RUN or DRAIN)
//   done            out  run finished, results held
//   pass            out  done with zero mismatches
//   err_cnt         out  mismatching compares, saturating
//   first_fail_idx  out  0-based compare index of the first mismatch
//   first_fail_exp  out  golden {N22,N23} at the first mismatch
//   first_fail_got  out  DUT {N22,N23} at the first mismatch
//   signature       out  MISR over DUT responses
// -----------------------------------------------------------------------------
module c17_response_checker #(
    parameter int LATENCY = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             sync_reset,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vec,
    input  logic             vec_valid,
    input  logic [4:0]       vec_in,
    input  logic             N22,
    input  logic             N23,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [1:0]       first_fail_exp,
    output logic [1:0]       first_fail_got,
    output logic [15:0]      signature
);

    localparam logic [CNT_W-1:0]   ONE           = CNT_W'(1);
    localparam logic [15:0]        MISR_POLY     = 16'h1021;
    localparam logic [LATENCY-1:0] ALL_STAGES    = '1;
    // Every stage except the last one: entries that still have to travel.
    localparam logic [LATENCY-1:0] UPSTREAM_MASK = ALL_STAGES >> 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0] num_lat;
    logic [CNT_W-1:0] acc_cnt;
    logic [CNT_W-1:0] acc_next;
    logic [CNT_W-1:0] cmp_cnt;

    logic             start_ok;
    logic             accept;
    logic             cmp_fire;
    logic             mismatch;
    logic             pending_upstream;
    logic [1:0]       got;
    logic [1:0]       exp_tail;

    logic [LATENCY-1:0] vld_p;
    logic [1:0]         exp_p [LATENCY];

    // Golden c17 NAND network, vector ordered {N1,N2,N3,N6,N7}.
    function automatic logic [1:0] c17_golden(input logic [4:0] v);
        logic n1, n2, n3, n6, n7;
        logic n10, n11, n16, n19;
        n1  = v[4];
        n2  = v[3];
        n3  = v[2];
        n6  = v[1];
        n7  = v[0];
        n10 = ~(n1 & n3);
        n11 = ~(n3 & n6);
        n16 = ~(n2 & n11);
        n19 = ~(n11 & n7);
        return {~(n10 & n16), ~(n16 & n19)};
    endfunction

    // Saturating increment: the count sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + ONE;
    endfunction

    // One MISR step folding a 2-bit DUT response into the signature.
    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [1:0] r);
        return {s[14:0], 1'b0} ^ (s[15] ? MISR_POLY : 16'h0000) ^ {14'b0, r};
    endfunction

    assign start_ok         = start && ((state == IDLE) || (state == DONE));
    assign accept           = (state == RUN) && vec_valid;
    assign acc_next         = acc_cnt + ONE;
    assign got              = {N22, N23};
    assign exp_tail         = exp_p[LATENCY-1];
    assign cmp_fire         = vld_p[LATENCY-1];
    assign mismatch         = cmp_fire && (got != exp_tail);
    assign pending_upstream = |(vld_p & UPSTREAM_MASK);

    // ---- stage 0..LATENCY-1: expected-response pipeline (valid bits) ----
    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= accept;
            for (int i = 1; i < LATENCY; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    // ---- stage 0..LATENCY-1: expected-response pipeline (data) ----
    // Data shifts every cycle; only the valid bits decide whether it counts.
    always_ff @(posedge clk) begin
        exp_p[0] <= c17_golden(vec_in);
        for (int i = 1; i < LATENCY; i++) begin
            exp_p[i] <= exp_p[i-1];
        end
    end

    // ---- FSM state register ----
    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---- FSM next state and status outputs ----
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        pass       = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = (num_vec == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (accept && (acc_next == num_lat)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // The final stage may be comparing right now; once nothing
                // is left behind it, this edge retires the last compare.
                if (!pending_upstream) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
        busy = (state == RUN) || (state == DRAIN);
        done = (state == DONE);
        pass = done && (err_cnt == '0);
    end

    // ---- stage LATENCY: compare, count, capture, signature ----
    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) begin
            num_lat        <= '0;
            acc_cnt        <= '0;
            cmp_cnt        <= '0;
            err_cnt        <= '0;
            first_fail_idx <= '0;
            first_fail_exp <= '0;
            first_fail_got <= '0;
            signature      <= '0;
        end else if (start_ok) begin
            num_lat        <= num_vec;
            acc_cnt        <= '0;
            cmp_cnt        <= '0;
            err_cnt        <= '0;
            first_fail_idx <= '0;
            first_fail_exp <= '0;
            first_fail_got <= '0;
            signature      <= '0;
        end else begin
            if (accept) begin
                acc_cnt <= acc_next;
            end
            if (cmp_fire) begin
                cmp_cnt   <= cmp_cnt + ONE;
                signature <= misr_step(signature, got);
                if (mismatch) begin
                    err_cnt <= sat_inc(err_cnt);
                    // err_cnt is only cleared by a new run, so zero here
                    // means this is the first mismatch of the run.
                    if (err_cnt == '0) begin
                        first_fail_idx <= cmp_cnt;
                        first_fail_exp <= exp_tail;
                        first_fail_got <= got;
                    end
                end
            end
        end
    end

endmodule
